uart_rx_core: RTL and testbench

Parametrised UART receive core, the next generation of the fixed 8-bit receiver. It oversamples the serial line 16x from a runtime-programmable divisor and rejects glitched start bits. Data width, parity mode and stop-bit count are configurable, and each received word is buffered with its error flags in a small FIFO. It sits between the pad-side serial input and any consumer using a valid/ready stream, replacing the old baud generator, SIPO, deframe and error-check chain.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_core.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive core.
// Holds the parity mode encoding, the error-flag bit positions, the
// oversample rate and the receiver FSM state encoding.
package uart_pkg;

  localparam int OS_RATE = 16;

  // Bit positions inside the 3-bit error field stored with each word.
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;

  // 2'b11 is not listed and decodes as "no parity".
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  function automatic logic par_enabled(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received words.
// Ports: clk/rst (sync, active high); push/wdata write side; pop/rdata
// read side with rdata always showing the head entry; empty/full status.
// A push while full succeeds only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0]                 wr_q, wr_d, rd_q, rd_d;
  logic                        do_push, do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (do_pop) rd_d = rd_q + (AW+1)'(1);
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling, glitch-rejecting start detection,
// configurable data width / parity / stop bits, FWFT output buffer.
// Ports: clk, rst (sync, active high); rx_i serial line (idle high);
// baud_div tick period-1, parity_type, stop2 (latched per frame);
// busy while framing; m_valid/m_ready/m_data/m_err output stream;
// overrun pulses when a finished word is dropped on a full buffer.
import uart_pkg::*;

module uart_rx_core #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_type,
  input  logic              stop2,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        m_err,
  output logic              overrun
);
  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = $clog2(DATA_W);
  localparam int FW   = DATA_W + 3;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d, div_q, div_d;
  logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [1:0]         par_q, par_d;
  logic               stop2_q, stop2_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_bit_q, par_bit_d, par_err_q, par_err_d;
  logic               frm_q, frm_d, brk_q, brk_d;
  logic               busy_q, busy_d, overrun_q, overrun_d;

  logic               tick, par_on, brk_now, frm_now, push;
  logic               fifo_pop, fifo_empty, fifo_full;
  logic [2:0]         err_w;
  logic [FW-1:0]      fifo_rdata;

  assign tick   = (tick_cnt_q == div_q);
  assign par_on = par_enabled(par_q);

  // Break is judged on the first stop sample; a later stop sample only
  // adds framing. Break always implies framing.
  assign brk_now = !stop_cnt_q ? ((shift_q == '0) && !(par_on && par_bit_q) && !rx_s_q)
                               : brk_q;
  assign frm_now = frm_q | !rx_s_q | brk_now;

  always_comb begin
    err_w          = '0;
    err_w[ERR_PAR] = par_err_q;
    err_w[ERR_FRM] = frm_now;
    err_w[ERR_BRK] = brk_now;
  end

  assign fifo_pop = !fifo_empty && m_ready;

  always_comb begin
    rx_meta_d  = rx_i;
    rx_s_d     = rx_meta_q;
    rx_prev_d  = rx_s_q;
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_d      = frm_q;
    brk_d      = brk_q;
    busy_d     = busy_q;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q && rx_prev_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          os_cnt_d   = '0;
          div_d      = baud_div;
          par_d      = parity_type;
          stop2_d    = stop2;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          frm_d      = 1'b0;
          brk_d      = 1'b0;
          stop_cnt_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OS_RATE/2 - 1)) begin
            // Line must still be low at mid start bit, else it was a glitch.
            if (!rx_s_q) begin
              state_d   = ST_DATA;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          // os_cnt wraps naturally, so each sample is exactly OS_RATE ticks apart.
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_W'(OS_RATE - 1)) begin
            case (state_q)
              ST_DATA: begin
                shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                  state_d    = par_on ? ST_PARITY : ST_STOP;
                  stop_cnt_d = 1'b0;
                end
              end
              ST_PARITY: begin
                par_bit_d = rx_s_q;
                par_err_d = (par_q == PAR_ODD) ? ~(^{shift_q, rx_s_q}) : (^{shift_q, rx_s_q});
                state_d   = ST_STOP;
              end
              ST_STOP: begin
                stop_cnt_d = 1'b1;
                brk_d      = brk_now;
                frm_d      = frm_now;
                if (stop_cnt_q || !stop2_q) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
    overrun_d = push && fifo_full && !fifo_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_q      <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_q      <= frm_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  uart_rx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({err_w, shift_q}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_rdata[DATA_W-1:0];
  assign m_err   = fifo_rdata[FW-1:DATA_W];

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised self-checking bench for uart_rx_core. Frames are built bit
// by bit from the line format; expected words and error flags come from
// a frame-level model and are matched in order as the stream pops them.
module tb_uart_rx_core;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, rx7 = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  ptype = 2'b10;
  logic        stop2 = 1'b0, m_ready = 1'b0, m_ready7 = 1'b0;
  logic        busy, m_valid, overrun, busy7, m_valid7, overrun7;
  logic [7:0]  m_data;
  logic [6:0]  m_data7;
  logic [2:0]  m_err, m_err7;

  typedef struct packed { logic [8:0] d; logic [2:0] e; } word_t;
  word_t exp_q[$];
  int    n_tests = 0, n_fail = 0, ovr_cnt = 0;
  bit    rr_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rx_i(rx), .baud_div(baud_div), .parity_type(ptype),
    .stop2(stop2), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_err(m_err), .overrun(overrun));

  uart_rx_core #(.DATA_W(7), .DIV_W(16), .FIFO_DEPTH(4)) u_dut7 (
    .clk(clk), .rst(rst), .rx_i(rx7), .baud_div(baud_div), .parity_type(ptype),
    .stop2(stop2), .busy(busy7), .m_valid(m_valid7), .m_ready(m_ready7),
    .m_data(m_data7), .m_err(m_err7), .overrun(overrun7));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bclk();
    return 16 * (int'(baud_div) + 1);
  endfunction

  // Frame-level error rules: parity check, stop-bit check, all-zero break.
  function automatic logic [2:0] exp_err(input int w, input logic [8:0] d, input logic [1:0] pt,
                                         input logic pb, input logic s1, input logic s2b,
                                         input logic st2);
    logic [8:0] m;
    logic pen, x, perr, brk, frm;
    m    = d & 9'((1 << w) - 1);
    pen  = (pt == 2'b01) || (pt == 2'b10);
    x    = (^m) ^ pb;
    perr = pen && ((pt == 2'b01) ? !x : x);
    brk  = (m == 9'd0) && (!pen || !pb) && !s1;
    frm  = !s1 || (st2 && !s2b) || brk;
    return {brk, frm, perr};
  endfunction

  task automatic send(input int w, input logic [8:0] d, input logic pflip, input logic s1,
                      input logic s2b, input bit to7, input bit expect_push);
    logic [15:0] bits;
    logic [8:0]  m;
    logic        pen, pb;
    int          n;
    m    = d & 9'((1 << w) - 1);
    pen  = (ptype == 2'b01) || (ptype == 2'b10);
    pb   = ((ptype == 2'b01) ? ~(^m) : (^m)) ^ pflip;
    bits = '0;
    n    = 1;
    for (int i = 0; i < w; i++) begin bits[n] = m[i]; n++; end
    if (pen) begin bits[n] = pb; n++; end
    bits[n] = s1; n++;
    if (stop2) begin bits[n] = s2b; n++; end
    if (expect_push && !to7) exp_q.push_back({m, exp_err(w, m, ptype, pb, s1, s2b, stop2)});
    for (int i = 0; i < n; i++) begin
      if (to7) rx7 = bits[i]; else rx = bits[i];
      cyc(bclk());
    end
    rx = 1'b1; rx7 = 1'b1;
    cyc(bclk());
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin cyc(1); n++; end
    check(tag, exp_q.size(), 0);
  endtask

  // Stream monitor: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && overrun) ovr_cnt++;
    if (!rst && m_valid && m_ready) begin
      check("pop_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        word_t w;
        w = exp_q.pop_front();
        check("m_data", m_data, w.d[7:0]);
        check("m_err", m_err, w.e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  o0, bsy_seen, vld_seen;
    logic [8:0] c3;
    cyc(5); rst = 1'b0; cyc(2);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_err", m_err, 0);
    check("rst_overrun", overrun, 0);

    // Clean frame, even parity
    m_ready = 1'b1; baud_div = 16'd3; ptype = 2'b10; stop2 = 1'b0;
    send(8, 9'hA5, 0, 1, 1, 0, 1);
    check("clean_busy_low", busy, 0);
    wait_drain("clean_drain");

    // Odd parity with wrong parity bit
    ptype = 2'b01;
    send(8, 9'h01, 1, 1, 1, 0, 1);
    wait_drain("parerr_drain");

    // 7-bit receiver, correct odd parity
    send(7, 9'h7F, 0, 1, 1, 1, 0);
    check("w7_valid", m_valid7, 1);
    check("w7_data", m_data7, 7'h7F);
    check("w7_err", m_err7, 3'b000);

    // Second stop bit low
    ptype = 2'b10; stop2 = 1'b1;
    send(8, 9'h55, 0, 1, 0, 0, 1);
    wait_drain("frm_drain");

    // Break: line low for 12 bit times
    stop2 = 1'b0;
    exp_q.push_back({9'h000, exp_err(8, 9'h000, ptype, 1'b0, 1'b0, 1'b1, stop2)});
    rx = 1'b0; cyc(12 * bclk());
    rx = 1'b1; cyc(2 * bclk());
    wait_drain("brk_drain");

    // Glitch: 16 clk low, then idle
    bsy_seen = 0; vld_seen = 0;
    rx = 1'b0;
    for (int i = 0; i < 16; i++) begin cyc(1); if (busy) bsy_seen = 1; end
    rx = 1'b1;
    for (int i = 0; i < 2 * bclk(); i++) begin
      cyc(1);
      if (busy) bsy_seen = 1;
      if (m_valid) vld_seen = 1;
    end
    check("glitch_busy_seen", bsy_seen, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_push", vld_seen, 0);

    // Overrun: fifth word dropped while consumer stalls
    m_ready = 1'b0; o0 = ovr_cnt;
    send(8, 9'h11, 0, 1, 1, 0, 1);
    send(8, 9'h22, 0, 1, 1, 0, 1);
    send(8, 9'h33, 0, 1, 1, 0, 1);
    send(8, 9'h44, 0, 1, 1, 0, 1);
    check("ovr_none_yet", ovr_cnt - o0, 0);
    send(8, 9'h55, 0, 1, 1, 0, 0);
    check("ovr_once", ovr_cnt - o0, 1);
    check("ovr_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_drain("ovr_drain");
    cyc(2);
    check("ovr_empty", m_valid, 0);

    // Reset in the middle of a data field
    c3 = 9'h0C3;
    rx = 1'b0; cyc(bclk());
    for (int i = 0; i < 3; i++) begin rx = c3[i]; cyc(bclk()); end
    rx = 1'b1; rst = 1'b1; cyc(3); rst = 1'b0; cyc(1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", m_valid, 0);
    cyc(2 * bclk());
    send(8, 9'h03C, 0, 1, 1, 0, 1);
    wait_drain("midrst_drain");

    // Random frames with random consumer back-pressure
    rr_en = 1'b1; o0 = ovr_cnt;
    for (int k = 0; k < 16; k++) begin
      baud_div = 16'($urandom_range(0, 3));
      ptype    = 2'($urandom_range(0, 3));
      stop2    = 1'($urandom_range(0, 1));
      send(8, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0), 0, 1);
    end
    wait_drain("rand_drain");
    check("rand_no_overrun", ovr_cnt - o0, 0);
    rr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
